seg7_scan_ctrl: RTL

Time-multiplexing scan controller for the 8-digit seven-segment display path.
- Holds eight 4-bit digit values written by a host interface.
- Steps through the digits in order, driving `num`/`sel` to the existing hex-to-segment decoder and anode select stage.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the system logic and the seven-segment decoder. The board anode/segment pins remain driven by the decoder; `blank` gates them off.

---
 rtl/seg7_scan_if.sv | 23 ++
 rtl/seg7_scan_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Host-side bus of the seven-segment scan controller: digit writes and masks in,
// decoder drive (num/sel/blank) and frame pulse out.
interface seg7_scan_if;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] digit_mask;
    logic [3:0] num;
    logic [2:0] sel;
    logic       blank;
    logic       frame_done;

    modport master (
        output en, wr_en, wr_addr, wr_data, digit_mask,
        input  num, sel, blank, frame_done
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, digit_mask,
        output num, sel, blank, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit time-multiplexed scan controller with inter-digit blanking gap.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [3:0]       digit_q [8];
    logic [3:0]       digit_d [8];
    logic [3:0]       num_q, num_d;
    logic             blank_q, blank_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       lz_vis_s;

    // Digit register file update from host writes.
    always_comb begin
        digit_d = digit_q;
        if (bus.wr_en) begin
            digit_d[bus.wr_addr] = bus.wr_data;
        end else begin
            digit_d = digit_q;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic nz_s;

    // A digit stays visible once any digit at or above its index is nonzero.
    always_comb begin
        nz_s     = 1'b0;
        lz_vis_s = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            nz_s        = nz_s | (|digit_q[i]);
            lz_vis_s[i] = nz_s || (i == 0);
        end
    end
`else
    assign lz_vis_s = 8'hFF;
`endif

    // Scan sequencing; outputs are computed from next-state so they land with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        if (!bus.en) begin
            // Dropping enable wins over any terminal count this cycle.
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
            sel_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = {CNT_W{1'b0}};
                    sel_d   = 3'd0;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (BLANK_CYCLES == 0) begin
                            sel_d        = sel_q + 3'd1;
                            frame_done_d = (sel_q == 3'd7);
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d        = {CNT_W{1'b0}};
                        sel_d        = sel_q + 3'd1;
                        frame_done_d = (sel_q == 3'd7);
                        state_d      = SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    sel_d   = 3'd0;
                end
            endcase
        end
        blank_d = (state_d != SHOW) || !bus.digit_mask[sel_d] || !lz_vis_s[sel_d];
        num_d   = (state_d == SHOW) ? digit_q[sel_d] : num_q;
    end

    // State, counter, digit registers and registered decoder outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            sel_q        <= 3'd0;
            num_q        <= 4'd0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            num_q        <= num_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
            digit_q      <= digit_d;
        end
    end

    assign bus.num        = num_q;
    assign bus.sel        = sel_q;
    assign bus.blank      = blank_q;
    assign bus.frame_done = frame_done_q;
endmodule
